// File: rtl/pipeline_run_monitor_if.sv
// Bundles the run-control, event and status signals of the pipeline run monitor.
// master drives control/event strobes; slave is the monitor itself.
interface pipeline_run_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32
);
  localparam int SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  logic               enable;
  logic               clear;
  logic               trap_mem;
  logic [NUM_EVT-1:0] evt_in;
  logic [SEL_W-1:0]   sel;
  logic [CNT_W-1:0]   evt_count;
  logic [CNT_W-1:0]   cycle_count;
  logic [1:0]         state_out;
  logic               done;
  logic               timed_out;
  logic               dump_req;

  modport master (
    output enable, clear, trap_mem, evt_in, sel,
    input  evt_count, cycle_count, state_out, done, timed_out, dump_req
  );

  modport slave (
    input  enable, clear, trap_mem, evt_in, sel,
    output evt_count, cycle_count, state_out, done, timed_out, dump_req
  );
endinterface

// File: rtl/pipeline_run_monitor.sv
// End-of-run monitor: counts cycles and per-stage events, waits for the MEM-stage trap,
// drains, then holds DONE with a one-cycle dump request; a watchdog ends runs that never trap.
module pipeline_run_monitor #(
  parameter int NUM_EVT      = 4,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 1,
  parameter int TIMEOUT      = 2000
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_run_monitor_if.slave bus
);
  localparam int DC_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  // A limit the saturating cycle counter can never reach would alias after truncation.
  localparam bit WD_EN = (TIMEOUT > 0) && (((64'(TIMEOUT) - 64'd1) >> CNT_W) == 64'd0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] evt_q [NUM_EVT];
  logic [DC_W-1:0]  drain_q;
  logic             timed_out_q;
  logic             dump_q;
  logic             wd_hit, wd_fire, drain_end, count_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wd_hit    = WD_EN && (cycle_q == WD_LAST);
  assign drain_end = (drain_q == DC_W'(DRAIN_LAST));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.enable) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.trap_mem) begin
          state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else if (wd_hit) begin
          state_d = ST_DONE;
          wd_fire = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_end) begin
          state_d = ST_DONE;
        end else if (wd_hit) begin
          state_d = ST_DONE;
          wd_fire = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.clear) begin
      state_d = ST_IDLE;
      wd_fire = 1'b0;
    end
  end

  always_comb begin
    count_en      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    bus.done      = (state_q == ST_DONE);
    bus.state_out = state_q;
  end

  // NOTE: the event counters are a small flop array, not a RAM, and must read zero after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q     <= '0;
      drain_q     <= '0;
      timed_out_q <= 1'b0;
      dump_q      <= 1'b0;
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
    end else if (bus.clear) begin
      cycle_q     <= '0;
      drain_q     <= '0;
      timed_out_q <= 1'b0;
      dump_q      <= 1'b0;
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
    end else begin
      if (count_en) begin
        cycle_q <= sat_inc(cycle_q);
        for (int i = 0; i < NUM_EVT; i++) begin
          if (bus.evt_in[i]) evt_q[i] <= sat_inc(evt_q[i]);
        end
      end
      if (state_q == ST_RUN)        drain_q <= '0;
      else if (state_q == ST_DRAIN) drain_q <= drain_q + DC_W'(1);
      if (wd_fire) timed_out_q <= 1'b1;
      dump_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  always_comb begin
    bus.evt_count = '0;
    if (int'(bus.sel) < NUM_EVT) bus.evt_count = evt_q[bus.sel];
  end

  assign bus.cycle_count = cycle_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.dump_req    = dump_q;
endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Self-checking bench for pipeline_run_monitor: trap-terminated runs from a vector table with a
// scoreboard, plus watchdog, trap/timeout coincidence, saturation, zero-drain and reset sequences.
module tb_pipeline_run_monitor;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: default build; b: small watchdog; c: 4-bit counters, no drain, no watchdog, 3 channels
  pipeline_run_monitor_if #(.NUM_EVT(4), .CNT_W(32)) bus_a ();
  pipeline_run_monitor_if #(.NUM_EVT(4), .CNT_W(8))  bus_b ();
  pipeline_run_monitor_if #(.NUM_EVT(3), .CNT_W(4))  bus_c ();

  pipeline_run_monitor #(.NUM_EVT(4), .CNT_W(32), .DRAIN_CYCLES(1), .TIMEOUT(2000)) dut_a (
    .clock(clk), .reset(rst_n), .bus(bus_a.slave));
  pipeline_run_monitor #(.NUM_EVT(4), .CNT_W(8), .DRAIN_CYCLES(1), .TIMEOUT(20)) dut_b (
    .clock(clk), .reset(rst_n), .bus(bus_b.slave));
  pipeline_run_monitor #(.NUM_EVT(3), .CNT_W(4), .DRAIN_CYCLES(0), .TIMEOUT(0)) dut_c (
    .clock(clk), .reset(rst_n), .bus(bus_c.slave));

  typedef struct {
    int     trap_at;  // RUN cycle (1-based) carrying the trap
    int     n0;       // evt_in[0] high on RUN cycles 1..n0
    int     n2;       // evt_in[2] high on RUN cycles 1..n2
    bit     hold3;    // evt_in[3] held high from RUN through DONE
    longint exp_cyc;
    longint exp_e0, exp_e1, exp_e2, exp_e3;
  } vec_t;

  typedef struct {
    longint cyc;
    longint e [4];
  } exp_t;

  vec_t vecs [4];
  exp_t sb_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    bit   seen;
    @(negedge clk); bus_a.enable = 1'b1;
    @(negedge clk); bus_a.enable = 1'b0;
    check($sformatf("v%0d_run_state", idx), 64'(bus_a.state_out), 64'd1);
    for (int c = 1; c <= v.trap_at; c++) begin
      bus_a.evt_in   = {v.hold3, (c <= v.n2), 1'b0, (c <= v.n0)};
      bus_a.trap_mem = (c == v.trap_at);
      if (c == v.trap_at) begin
        e.cyc = v.exp_cyc;
        e.e   = '{v.exp_e0, v.exp_e1, v.exp_e2, v.exp_e3};
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    bus_a.trap_mem = 1'b0;
    bus_a.evt_in   = {v.hold3, 3'b000};
    check($sformatf("v%0d_drain_state", idx), 64'(bus_a.state_out), 64'd2);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (bus_a.dump_req) seen = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("v%0d_dump_seen", idx), 64'(seen), 64'd1);
    e = sb_q.pop_front();
    if (seen) begin
      check($sformatf("v%0d_cycles", idx), 64'(bus_a.cycle_count), 64'(e.cyc));
      check($sformatf("v%0d_done", idx), 64'(bus_a.done), 64'd1);
      check($sformatf("v%0d_timed_out", idx), 64'(bus_a.timed_out), 64'd0);
      for (int s = 0; s < 4; s++) begin
        bus_a.sel = 2'(s);
        #1;
        check($sformatf("v%0d_evt%0d", idx, s), 64'(bus_a.evt_count), 64'(e.e[s]));
      end
      @(negedge clk);
      check($sformatf("v%0d_dump_single", idx), 64'(bus_a.dump_req), 64'd0);
      check($sformatf("v%0d_evt3_frozen", idx), 64'(bus_a.evt_count), 64'(e.e[3]));
      check($sformatf("v%0d_cycles_frozen", idx), 64'(bus_a.cycle_count), 64'(e.cyc));
    end
    bus_a.evt_in = '0;
    bus_a.sel    = '0;
    bus_a.clear  = 1'b1;
    @(negedge clk); bus_a.clear = 1'b0;
    check($sformatf("v%0d_clear_state", idx), 64'(bus_a.state_out), 64'd0);
    check($sformatf("v%0d_clear_cycles", idx), 64'(bus_a.cycle_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pulses, first;
    bit saw_drain;

    vecs[0] = '{10, 0, 0, 1'b0, 11, 0, 0, 0, 0};
    vecs[1] = '{12, 5, 3, 1'b0, 13, 5, 0, 3, 0};
    vecs[2] = '{1,  0, 0, 1'b1, 2,  0, 0, 0, 2};
    vecs[3] = '{7,  7, 7, 1'b1, 8,  7, 0, 7, 8};

    {bus_a.enable, bus_a.clear, bus_a.trap_mem} = '0; bus_a.evt_in = '0; bus_a.sel = '0;
    {bus_b.enable, bus_b.clear, bus_b.trap_mem} = '0; bus_b.evt_in = '0; bus_b.sel = '0;
    {bus_c.enable, bus_c.clear, bus_c.trap_mem} = '0; bus_c.evt_in = '0; bus_c.sel = '0;

    repeat (2) @(negedge clk);
    check("reset_state", 64'(bus_a.state_out), 64'd0);
    check("reset_cycles", 64'(bus_a.cycle_count), 64'd0);
    check("reset_done", 64'(bus_a.done), 64'd0);
    check("reset_dump", 64'(bus_a.dump_req), 64'd0);
    check("reset_timed_out", 64'(bus_a.timed_out), 64'd0);
    rst_n = 1'b1;

    // IDLE holds with enable low, and clear beats enable
    @(negedge clk);
    check("idle_hold", 64'(bus_a.state_out), 64'd0);
    bus_a.enable = 1'b1; bus_a.clear = 1'b1;
    @(negedge clk);
    bus_a.enable = 1'b0; bus_a.clear = 1'b0;
    check("clear_beats_enable", 64'(bus_a.state_out), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // watchdog: 20 RUN cycles without a trap
    @(negedge clk); bus_b.enable = 1'b1;
    @(negedge clk); bus_b.enable = 1'b0;
    pulses = 0; first = -1;
    for (int c = 1; c <= 40; c++) begin
      if (bus_b.dump_req) begin
        pulses++;
        if (first < 0) begin
          first = c;
          check("wd_cycles", 64'(bus_b.cycle_count), 64'd20);
          check("wd_timed_out", 64'(bus_b.timed_out), 64'd1);
          check("wd_state", 64'(bus_b.state_out), 64'd3);
        end
      end
      @(negedge clk);
    end
    check("wd_done_after_20_run", 64'(first), 64'd21);
    check("wd_single_dump", 64'(pulses), 64'd1);
    bus_b.clear = 1'b1;
    @(negedge clk); bus_b.clear = 1'b0;
    check("wd_clear_timed_out", 64'(bus_b.timed_out), 64'd0);

    // trap on the very cycle the watchdog would expire
    @(negedge clk); bus_b.enable = 1'b1;
    @(negedge clk); bus_b.enable = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      bus_b.trap_mem = (c == 20);
      @(negedge clk);
    end
    bus_b.trap_mem = 1'b0;
    check("coinc_drain_state", 64'(bus_b.state_out), 64'd2);
    check("coinc_drain_timed_out", 64'(bus_b.timed_out), 64'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus_b.dump_req) begin
        pulses++;
        check("coinc_cycles", 64'(bus_b.cycle_count), 64'd21);
        check("coinc_timed_out", 64'(bus_b.timed_out), 64'd0);
      end
      @(negedge clk);
    end
    check("coinc_single_dump", 64'(pulses), 64'd1);
    bus_b.clear = 1'b1;
    @(negedge clk); bus_b.clear = 1'b0;

    // 4-bit saturation with zero drain, then a second trap inside DONE
    @(negedge clk); bus_c.enable = 1'b1;
    @(negedge clk); bus_c.enable = 1'b0;
    saw_drain = 1'b0;
    bus_c.evt_in = 3'b010;
    for (int c = 1; c <= 40; c++) begin
      bus_c.trap_mem = (c == 40);
      @(negedge clk);
      if (bus_c.state_out == 2'd2) saw_drain = 1'b1;
    end
    bus_c.trap_mem = 1'b0;
    check("nodrain_state", 64'(bus_c.state_out), 64'd3);
    check("nodrain_dump", 64'(bus_c.dump_req), 64'd1);
    check("nodrain_never_drain", 64'(saw_drain), 64'd0);
    check("sat_cycles", 64'(bus_c.cycle_count), 64'd15);
    check("sat_timed_out", 64'(bus_c.timed_out), 64'd0);
    for (int s = 0; s < 4; s++) begin
      bus_c.sel = 2'(s);
      #1;
      check($sformatf("sat_evt%0d", s), 64'(bus_c.evt_count), (s == 1) ? 64'd15 : 64'd0);
    end
    @(negedge clk); bus_c.trap_mem = 1'b1;
    @(negedge clk); bus_c.trap_mem = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus_c.dump_req) pulses++;
      @(negedge clk);
    end
    check("second_trap_no_dump", 64'(pulses), 64'd0);
    check("second_trap_state", 64'(bus_c.state_out), 64'd3);
    bus_c.evt_in = '0;
    bus_c.clear  = 1'b1;
    @(negedge clk); bus_c.clear = 1'b0;
    check("c_clear_state", 64'(bus_c.state_out), 64'd0);

    // asynchronous reset in the middle of DRAIN
    @(negedge clk); bus_a.enable = 1'b1;
    @(negedge clk); bus_a.enable = 1'b0;
    bus_a.evt_in = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      bus_a.trap_mem = (c == 3);
      @(negedge clk);
    end
    bus_a.trap_mem = 1'b0;
    check("rst_pre_drain", 64'(bus_a.state_out), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_state", 64'(bus_a.state_out), 64'd0);
    check("rst_async_cycles", 64'(bus_a.cycle_count), 64'd0);
    check("rst_async_evt0", 64'(bus_a.evt_count), 64'd0);
    check("rst_async_dump", 64'(bus_a.dump_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.evt_in = '0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_a.dump_req) pulses++;
    end
    check("rst_no_dump", 64'(pulses), 64'd0);
    check("rst_idle_after", 64'(bus_a.state_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
